// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: ROB sizing parameters, index/count types and the entry record
package rob_commit_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int PREG_W = 6;
  localparam int XLEN = 32;
  typedef logic [ROB_IDX_W-1:0] idx_t;
  typedef logic [ROB_IDX_W:0] cnt_t;
  typedef struct packed {
    logic v;
    logic typ;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] opd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
    logic comp;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit_if.sv
// rob_commit_if: dispatch, completion and retire signals of the ROB
interface rob_commit_if;
  import rob_commit_pkg::*;
  logic alloc_valid_1, alloc_valid_2, alloc_type_1, alloc_type_2;
  logic [PREG_W-1:0] alloc_pd_1, alloc_pd_2, alloc_opd_1, alloc_opd_2;
  logic alloc_ready;
  logic [ROB_IDX_W-1:0] alloc_idx_1, alloc_idx_2;
  logic cmp_valid_a, cmp_valid_b;
  logic [ROB_IDX_W-1:0] cmp_idx_a, cmp_idx_b;
  logic [XLEN-1:0] cmp_data_a, cmp_data_b, cmp_addr_a, cmp_addr_b;
  logic ret_valid_1, ret_valid_2, ret_type_1, ret_type_2;
  logic [PREG_W-1:0] ret_pd_1, ret_pd_2, ret_opd_1, ret_opd_2;
  logic [XLEN-1:0] ret_data_1, ret_data_2, ret_addr_1, ret_addr_2;
  logic rob_empty;
  modport master (
    output alloc_valid_1, alloc_valid_2, alloc_type_1, alloc_type_2,
           alloc_pd_1, alloc_pd_2, alloc_opd_1, alloc_opd_2,
           cmp_valid_a, cmp_valid_b, cmp_idx_a, cmp_idx_b,
           cmp_data_a, cmp_data_b, cmp_addr_a, cmp_addr_b,
    input  alloc_ready, alloc_idx_1, alloc_idx_2,
           ret_valid_1, ret_valid_2, ret_type_1, ret_type_2,
           ret_pd_1, ret_pd_2, ret_opd_1, ret_opd_2,
           ret_data_1, ret_data_2, ret_addr_1, ret_addr_2, rob_empty
  );
  modport slave (
    input  alloc_valid_1, alloc_valid_2, alloc_type_1, alloc_type_2,
           alloc_pd_1, alloc_pd_2, alloc_opd_1, alloc_opd_2,
           cmp_valid_a, cmp_valid_b, cmp_idx_a, cmp_idx_b,
           cmp_data_a, cmp_data_b, cmp_addr_a, cmp_addr_b,
    output alloc_ready, alloc_idx_1, alloc_idx_2,
           ret_valid_1, ret_valid_2, ret_type_1, ret_type_2,
           ret_pd_1, ret_pd_2, ret_opd_1, ret_opd_2,
           ret_data_1, ret_data_2, ret_addr_1, ret_addr_2, rob_empty
  );
endinterface

// File: rtl/rob_commit_retire_sel.sv
// rob_retire_sel: picks up to two in-order retires from the head, at most one store per cycle
module rob_retire_sel
  import rob_commit_pkg::*;
(
  input  rob_entry_t head_i,
  input  rob_entry_t next_i,
  output logic       r1_o,
  output logic       r2_o
);
  logic unused_bits;
  assign r1_o = head_i.v && head_i.comp;
  assign r2_o = r1_o && next_i.v && next_i.comp && !(head_i.typ && next_i.typ);
  assign unused_bits = ^{head_i.pd, head_i.opd, head_i.data, head_i.addr,
                         next_i.pd, next_i.opd, next_i.data, next_i.addr};
endmodule

// File: rtl/rob_commit.sv
// rob_commit: 2-wide re-order buffer with in-order 2-wide retire
module rob_commit
  import rob_commit_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave bus
);
  rob_entry_t rob_q [ROB_DEPTH];
  rob_entry_t ret1_q, ret2_q;
  idx_t head_q, tail_q, head1, tail1;
  cnt_t count_q, count_d;
  logic r1, r2, a1, a2, ready, unused_bits;
  assign head1 = head_q + idx_t'(1);
  assign tail1 = tail_q + idx_t'(1);
  assign ready = count_q <= cnt_t'(ROB_DEPTH - 2);
  assign a1 = bus.alloc_valid_1 && ready;
  assign a2 = a1 && bus.alloc_valid_2;
  assign count_d = count_q + cnt_t'(a1) + cnt_t'(a2) - cnt_t'(r1) - cnt_t'(r2);
  rob_retire_sel u_sel (
    .head_i(rob_q[head_q]),
    .next_i(rob_q[head1]),
    .r1_o  (r1),
    .r2_o  (r2)
  );
  assign bus.alloc_ready = ready;
  assign bus.alloc_idx_1 = tail_q;
  assign bus.alloc_idx_2 = tail1;
  assign bus.rob_empty = count_q == '0;
  assign bus.ret_valid_1 = ret1_q.v;
  assign bus.ret_valid_2 = ret2_q.v;
  assign bus.ret_type_1 = ret1_q.typ;
  assign bus.ret_type_2 = ret2_q.typ;
  assign bus.ret_pd_1 = ret1_q.pd;
  assign bus.ret_pd_2 = ret2_q.pd;
  assign bus.ret_opd_1 = ret1_q.opd;
  assign bus.ret_opd_2 = ret2_q.opd;
  assign bus.ret_data_1 = ret1_q.data;
  assign bus.ret_data_2 = ret2_q.data;
  assign bus.ret_addr_1 = ret1_q.addr;
  assign bus.ret_addr_2 = ret2_q.addr;
  assign unused_bits = ret1_q.comp ^ ret2_q.comp;
  // Completion writes first (port a last so it wins), then retire clears, then allocation;
  // all conditions read pre-edge state, so a same-cycle completion never retires early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ret1_q <= '0;
      ret2_q <= '0;
    end else begin
      if (bus.cmp_valid_b && rob_q[bus.cmp_idx_b].v) begin
        rob_q[bus.cmp_idx_b].comp <= 1'b1;
        rob_q[bus.cmp_idx_b].data <= bus.cmp_data_b;
        rob_q[bus.cmp_idx_b].addr <= bus.cmp_addr_b;
      end
      if (bus.cmp_valid_a && rob_q[bus.cmp_idx_a].v) begin
        rob_q[bus.cmp_idx_a].comp <= 1'b1;
        rob_q[bus.cmp_idx_a].data <= bus.cmp_data_a;
        rob_q[bus.cmp_idx_a].addr <= bus.cmp_addr_a;
      end
      ret1_q.v <= r1;
      ret2_q.v <= r2;
      if (r1) begin
        ret1_q <= rob_q[head_q];
        rob_q[head_q].v <= 1'b0;
      end
      if (r2) begin
        ret2_q <= rob_q[head1];
        rob_q[head1].v <= 1'b0;
      end
      if (a1) rob_q[tail_q] <= '{v: 1'b1, typ: bus.alloc_type_1, pd: bus.alloc_pd_1,
                                 opd: bus.alloc_opd_1, data: '0, addr: '0, comp: 1'b0};
      if (a2) rob_q[tail1] <= '{v: 1'b1, typ: bus.alloc_type_2, pd: bus.alloc_pd_2,
                                opd: bus.alloc_opd_2, data: '0, addr: '0, comp: 1'b0};
      head_q <= head_q + idx_t'(r1) + idx_t'(r2);
      tail_q <= tail_q + idx_t'(a1) + idx_t'(a2);
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios plus randomized run against a queue-based ROB model
module tb_rob_commit;
  import rob_commit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rob_commit_if bus();
  rob_commit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int idx;
    bit typ;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] opd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
    bit comp;
  } m_ent_t;
  m_ent_t mq[$];
  m_ent_t m_r1, m_r2;
  bit m_rv1, m_rv2;
  int m_tail;
  int n_tests = 0;
  int n_fail = 0;
  function automatic void model_reset();
    mq.delete();
    m_r1 = '{default: 0};
    m_r2 = '{default: 0};
    m_rv1 = 0;
    m_rv2 = 0;
    m_tail = 0;
  endfunction
  function automatic void model_step();
    int sz = mq.size();
    bit r1, r2;
    r1 = sz > 0 && mq[0].comp;
    r2 = r1 && sz > 1 && mq[1].comp && !(mq[0].typ && mq[1].typ);
    m_rv1 = r1;
    m_rv2 = r2;
    if (r1) m_r1 = mq[0];
    if (r2) m_r2 = mq[1];
    foreach (mq[i]) if (bus.cmp_valid_b && mq[i].idx == int'(bus.cmp_idx_b)) begin
      mq[i].comp = 1;
      mq[i].data = bus.cmp_data_b;
      mq[i].addr = bus.cmp_addr_b;
    end
    foreach (mq[i]) if (bus.cmp_valid_a && mq[i].idx == int'(bus.cmp_idx_a)) begin
      mq[i].comp = 1;
      mq[i].data = bus.cmp_data_a;
      mq[i].addr = bus.cmp_addr_a;
    end
    if (r1) void'(mq.pop_front());
    if (r2) void'(mq.pop_front());
    if (bus.alloc_valid_1 && sz <= ROB_DEPTH - 2) begin
      mq.push_back('{m_tail, bus.alloc_type_1, bus.alloc_pd_1, bus.alloc_opd_1, 32'h0, 32'h0, 1'b0});
      m_tail = (m_tail + 1) % ROB_DEPTH;
      if (bus.alloc_valid_2) begin
        mq.push_back('{m_tail, bus.alloc_type_2, bus.alloc_pd_2, bus.alloc_opd_2, 32'h0, 32'h0, 1'b0});
        m_tail = (m_tail + 1) % ROB_DEPTH;
      end
    end
  endfunction
  task automatic idle();
    bus.alloc_valid_1 = 0; bus.alloc_valid_2 = 0;
    bus.alloc_type_1 = 0; bus.alloc_type_2 = 0;
    bus.alloc_pd_1 = '0; bus.alloc_pd_2 = '0; bus.alloc_opd_1 = '0; bus.alloc_opd_2 = '0;
    bus.cmp_valid_a = 0; bus.cmp_valid_b = 0;
    bus.cmp_idx_a = '0; bus.cmp_idx_b = '0;
    bus.cmp_data_a = '0; bus.cmp_data_b = '0; bus.cmp_addr_a = '0; bus.cmp_addr_b = '0;
  endtask
  task automatic set_alloc(input bit v1, input bit v2, input bit t1, input bit t2,
                           input int pd1, input int opd1, input int pd2, input int opd2);
    bus.alloc_valid_1 = v1; bus.alloc_valid_2 = v2;
    bus.alloc_type_1 = t1; bus.alloc_type_2 = t2;
    bus.alloc_pd_1 = PREG_W'(pd1); bus.alloc_opd_1 = PREG_W'(opd1);
    bus.alloc_pd_2 = PREG_W'(pd2); bus.alloc_opd_2 = PREG_W'(opd2);
  endtask
  task automatic set_cmp_a(input bit v, input int idx, input logic [XLEN-1:0] d, input logic [XLEN-1:0] a);
    bus.cmp_valid_a = v; bus.cmp_idx_a = ROB_IDX_W'(idx); bus.cmp_data_a = d; bus.cmp_addr_a = a;
  endtask
  task automatic set_cmp_b(input bit v, input int idx, input logic [XLEN-1:0] d, input logic [XLEN-1:0] a);
    bus.cmp_valid_b = v; bus.cmp_idx_b = ROB_IDX_W'(idx); bus.cmp_data_b = d; bus.cmp_addr_b = a;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  task automatic test_reset();
    do_reset();
    tick();
    n_tests++;
    if ({bus.rob_empty, bus.alloc_ready, bus.ret_valid_1, bus.ret_valid_2, bus.alloc_idx_1, bus.alloc_idx_2}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_state got empty=%b ready=%b rv=%b%b idx=%0d/%0d exp 1 1 00 0/1",
               bus.rob_empty, bus.alloc_ready, bus.ret_valid_1, bus.ret_valid_2, bus.alloc_idx_1, bus.alloc_idx_2);
    end
    n_tests++;
    if ({bus.ret_type_1, bus.ret_pd_1, bus.ret_opd_1, bus.ret_data_1, bus.ret_addr_1,
         bus.ret_type_2, bus.ret_pd_2, bus.ret_opd_2, bus.ret_data_2, bus.ret_addr_2} !== '0) begin
      n_fail++;
      $display("FAIL reset_ret_zero got pd=%0d/%0d data=%h/%h exp all zero",
               bus.ret_pd_1, bus.ret_pd_2, bus.ret_data_1, bus.ret_data_2);
    end
  endtask
  task automatic test_pair();
    do_reset();
    set_alloc(1, 1, 0, 0, 33, 5, 34, 6);
    tick();
    idle();
    set_cmp_a(1, 1, 32'hB, 32'h0);
    tick();
    idle();
    n_tests++;
    if (bus.ret_valid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pair_no_early got rv1=%b exp 0", bus.ret_valid_1);
    end
    set_cmp_a(1, 0, 32'hA, 32'h0);
    tick();
    idle();
    n_tests++;
    if (bus.ret_valid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL pair_same_cycle got rv1=%b exp 0", bus.ret_valid_1);
    end
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_pd_2, bus.ret_opd_1, bus.ret_opd_2,
         bus.ret_data_1, bus.ret_data_2} !== {1'b1, 1'b1, 6'd33, 6'd34, 6'd5, 6'd6, 32'hA, 32'hB}) begin
      n_fail++;
      $display("FAIL pair_retire got rv=%b%b pd=%0d/%0d opd=%0d/%0d data=%h/%h exp 11 33/34 5/6 a/b",
               bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_pd_2, bus.ret_opd_1, bus.ret_opd_2,
               bus.ret_data_1, bus.ret_data_2);
    end
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.rob_empty} !== {1'b0, 1'b0, 6'd33, 1'b1}) begin
      n_fail++;
      $display("FAIL pair_hold got rv=%b%b pd1=%0d empty=%b exp 00 33 1",
               bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.rob_empty);
    end
  endtask
  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(1, 1, 0, 0, 10 + 2 * i, 1, 11 + 2 * i, 2);
      tick();
      n_tests++;
      if (bus.alloc_ready !== (i < 7)) begin
        n_fail++;
        $display("FAIL fill_ready_%0d got %b exp %b", i, bus.alloc_ready, i < 7);
      end
    end
    set_alloc(1, 1, 0, 0, 60, 61, 62, 63);
    tick();
    idle();
    n_tests++;
    if ({bus.alloc_ready, bus.alloc_idx_1, bus.rob_empty} !== {1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_ninth got ready=%b idx1=%0d empty=%b exp 0 0 0", bus.alloc_ready, bus.alloc_idx_1, bus.rob_empty);
    end
    set_cmp_a(1, 0, 32'h1, 32'h0);
    set_cmp_b(1, 1, 32'h2, 32'h0);
    tick();
    idle();
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_pd_2, bus.alloc_ready} !== {1'b1, 1'b1, 6'd10, 6'd11, 1'b1}) begin
      n_fail++;
      $display("FAIL fill_drain got rv=%b%b pd=%0d/%0d ready=%b exp 11 10/11 1",
               bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_pd_2, bus.alloc_ready);
    end
  endtask
  task automatic test_stores();
    do_reset();
    set_alloc(1, 1, 1, 1, 0, 0, 0, 0);
    tick();
    idle();
    set_cmp_a(1, 0, 32'h11, 32'h40);
    set_cmp_b(1, 1, 32'h22, 32'h44);
    tick();
    idle();
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_type_1, bus.ret_addr_1, bus.ret_data_1} !== {1'b1, 1'b0, 1'b1, 32'h40, 32'h11}) begin
      n_fail++;
      $display("FAIL store_first got rv=%b%b type=%b addr=%h data=%h exp 10 1 40 11",
               bus.ret_valid_1, bus.ret_valid_2, bus.ret_type_1, bus.ret_addr_1, bus.ret_data_1);
    end
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_type_1, bus.ret_addr_1, bus.ret_data_1} !== {1'b1, 1'b0, 1'b1, 32'h44, 32'h22}) begin
      n_fail++;
      $display("FAIL store_second got rv=%b%b type=%b addr=%h data=%h exp 10 1 44 22",
               bus.ret_valid_1, bus.ret_valid_2, bus.ret_type_1, bus.ret_addr_1, bus.ret_data_1);
    end
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.rob_empty} !== 2'b01) begin
      n_fail++;
      $display("FAIL store_done got rv1=%b empty=%b exp 0 1", bus.ret_valid_1, bus.rob_empty);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_alloc(1, 1, 0, 0, i, 0, i, 0);
      tick();
    end
    idle();
    for (int k = 0; k < 7; k++) begin
      set_cmp_a(1, 2 * k, 32'h0, 32'h0);
      set_cmp_b(1, 2 * k + 1, 32'h0, 32'h0);
      tick();
    end
    idle();
    tick();
    tick();
    n_tests++;
    if ({bus.rob_empty, bus.alloc_idx_1} !== {1'b1, 4'd14}) begin
      n_fail++;
      $display("FAIL wrap_setup got empty=%b idx1=%0d exp 1 14", bus.rob_empty, bus.alloc_idx_1);
    end
    set_alloc(1, 0, 0, 0, 40, 1, 0, 0);
    tick();
    idle();
    n_tests++;
    if ({bus.alloc_idx_1, bus.alloc_idx_2} !== {4'd15, 4'd0}) begin
      n_fail++;
      $display("FAIL wrap_idx got %0d/%0d exp 15/0", bus.alloc_idx_1, bus.alloc_idx_2);
    end
    set_alloc(1, 1, 0, 0, 41, 2, 42, 3);
    tick();
    idle();
    set_cmp_a(1, 15, 32'hF, 32'h0);
    set_cmp_b(1, 0, 32'h10, 32'h0);
    tick();
    idle();
    set_cmp_a(1, 14, 32'hE, 32'h0);
    tick();
    idle();
    n_tests++;
    if (bus.ret_valid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_head_blocks got rv1=%b exp 0", bus.ret_valid_1);
    end
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_pd_2, bus.ret_data_1} !== {1'b1, 1'b1, 6'd40, 6'd41, 32'hE}) begin
      n_fail++;
      $display("FAIL wrap_first got rv=%b%b pd=%0d/%0d data1=%h exp 11 40/41 e",
               bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_pd_2, bus.ret_data_1);
    end
    tick();
    n_tests++;
    if ({bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_data_1} !== {1'b1, 1'b0, 6'd42, 32'h10}) begin
      n_fail++;
      $display("FAIL wrap_second got rv=%b%b pd1=%0d data1=%h exp 10 42 10",
               bus.ret_valid_1, bus.ret_valid_2, bus.ret_pd_1, bus.ret_data_1);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 1, 0, 0, 20 + i, 0, 30 + i, 0);
      tick();
    end
    idle();
    set_cmp_a(1, 0, 32'h5, 32'h0);
    set_cmp_b(1, 1, 32'h6, 32'h0);
    tick();
    set_cmp_a(1, 2, 32'h7, 32'h0);
    set_cmp_b(1, 3, 32'h8, 32'h0);
    rst = 1;
    #1;
    n_tests++;
    if ({bus.rob_empty, bus.alloc_ready, bus.ret_valid_1, bus.ret_valid_2} !== 4'b1100) begin
      n_fail++;
      $display("FAIL rstmid_async got empty=%b ready=%b rv=%b%b exp 1 1 00",
               bus.rob_empty, bus.alloc_ready, bus.ret_valid_1, bus.ret_valid_2);
    end
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    idle();
    tick();
    n_tests++;
    if ({bus.rob_empty, bus.ret_valid_1, bus.ret_valid_2, bus.alloc_idx_1} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rstmid_after got empty=%b rv=%b%b idx1=%0d exp 1 00 0",
               bus.rob_empty, bus.ret_valid_1, bus.ret_valid_2, bus.alloc_idx_1);
    end
  endtask
  task automatic test_random();
    logic [165:0] got, exp;
    int ap, cp, errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        ap = $urandom_range(1, 4);
        cp = $urandom_range(1, 4);
      end
      set_alloc($urandom_range(0, 3) < ap, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      bus.cmp_valid_a = $urandom_range(0, 3) < cp;
      bus.cmp_valid_b = $urandom_range(0, 3) < cp;
      bus.cmp_idx_a = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? ROB_IDX_W'(mq[$urandom_range(0, mq.size() - 1)].idx)
                                                                   : ROB_IDX_W'($urandom_range(0, 15));
      bus.cmp_idx_b = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? ROB_IDX_W'(mq[$urandom_range(0, mq.size() - 1)].idx)
                                                                   : ROB_IDX_W'($urandom_range(0, 15));
      bus.cmp_data_a = $urandom; bus.cmp_addr_a = $urandom;
      bus.cmp_data_b = $urandom; bus.cmp_addr_b = $urandom;
      tick();
      got = {bus.ret_valid_1, bus.ret_valid_2,
             bus.ret_type_1, bus.ret_pd_1, bus.ret_opd_1, bus.ret_data_1, bus.ret_addr_1,
             bus.ret_type_2, bus.ret_pd_2, bus.ret_opd_2, bus.ret_data_2, bus.ret_addr_2,
             bus.alloc_ready, bus.rob_empty, bus.alloc_idx_1, bus.alloc_idx_2};
      exp = {m_rv1, m_rv2,
             m_r1.typ, m_r1.pd, m_r1.opd, m_r1.data, m_r1.addr,
             m_r2.typ, m_r2.pd, m_r2.opd, m_r2.data, m_r2.addr,
             mq.size() <= ROB_DEPTH - 2, mq.size() == 0, ROB_IDX_W'(m_tail), ROB_IDX_W'(m_tail + 1)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle_%0d got %h exp %h", c, got, exp);
      end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_pair();
    test_fill();
    test_stores();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
